fifo_reader: RTL
================

Name: fifo_reader

Overview:
Drain-side companion to the team's fifo. It issues rdreq to a fifo read port, absorbs that fifo's read latency, and presents the words on a valid/ready stream with no combinational path from the sink's ready back to the fifo. Full throughput of one word per clock is sustained while the fifo is non-empty and the sink is ready. It sits between a fifo instance and any backpressuring consumer.

Parameters:
DWIDTH, 64, data width of fifo q and stream data.
READ_LATENCY, 1, clocks from rdreq to valid q on the fifo: 0 for showahead, 1 for normal, 2 for normal with registered output. The legal range is 0..3; anything else is an elaboration error.
CNT_WIDTH, 32, width of the delivered-word counter.

Ports:
clk_i  in  1  clock
srst_i  in  1  synchronous reset, active-low
fifo_q_i  in  DWIDTH  fifo read data
fifo_empty_i  in  1  fifo empty flag
fifo_rdreq_o  out  1  fifo read request
data_o  out  DWIDTH  stream data
valid_o  out  1  stream valid
ready_i  in  1  stream ready from sink
level_o  out  3  words held in internal buffer
words_o  out  CNT_WIDTH  count of words accepted by sink

Behaviour:
- Localparam BUF_DEPTH = READ_LATENCY + 2. The internal buffer is a circular buffer of BUF_DEPTH entries, with wr_ptr, rd_ptr and level registers.
- inflight: number of rdreqs issued whose data has not yet been captured. It is tracked by a READ_LATENCY-long shift register of valid bits, pipe[0..L-1]. pipe[0] <= fifo_rdreq_o and pipe[i] <= pipe[i-1]. inflight is the popcount of pipe.
- fifo_rdreq_o = fifo_empty_i==0 && (level + inflight) < BUF_DEPTH.
  - This is purely registered-state driven; ready_i is not in the equation.
  - This credit rule guarantees the buffer never overflows.
- Capture:
  - L=0: write fifo_q_i into the buffer in the same cycle fifo_rdreq_o=1.
  - L>=1: write fifo_q_i when pipe[L-1]=1.
  - Each write advances wr_ptr.
- Pop: pop = valid_o && ready_i. A pop advances rd_ptr.
- level updates as level + capture - pop. A simultaneous capture and pop leaves level unchanged.
- valid_o = (level != 0). data_o = buf[rd_ptr]. A pointer wraps from BUF_DEPTH-1 to 0.
- Stream rules:
  - Once valid_o=1, data_o is held stable until it is popped.
  - valid_o never depends on ready_i.
- words_o increments by 1 on each pop and wraps modulo 2^CNT_WIDTH.
- Empty boundary: with fifo_empty_i=1, no rdreq is issued. Reads already in flight still complete and are captured.
- Full buffer with ready_i=0: level reaches BUF_DEPTH, then fifo_rdreq_o=0. Nothing is lost. When ready_i returns to 1, the buffer drains at 1 word per clock and rdreq resumes.
- Reset (srst_i=0, sampled at posedge):
  - Cleared to 0: fifo_rdreq_o, pipe, level, wr_ptr, rd_ptr, valid_o, words_o. data_o is don't-care.
  - While srst_i=0, fifo_rdreq_o=0.
  - Reset mid-operation discards buffered and in-flight words. The fifo is reset by the same reset at the system level.
  - The first rdreq can assert on the first cycle after srst_i returns to 1.
- No protocol error outputs. The fifo's own read-when-empty protection is not relied upon; this block never requests while fifo_empty_i=1.

Test Plan:
- Streaming, L=1: fifo preloaded with 0x1..0x10, ready_i=1 constant. Expect 16 words 0x1..0x10 in order, back-to-back valid_o cycles after the initial 2-cycle latency, and words_o=16.
- Backpressure, L=2: 10 words loaded, ready_i=0 for 20 cycles. Expect level_o to saturate at 4 and fifo_rdreq_o=0 afterwards. After ready_i=1, expect all 10 words in order with no duplicates or drops.
- Showahead, L=0: 5 words loaded, random ready_i (50%). Expect 0 latency from the empty deassert to fifo_rdreq_o=1, and the output sequence to match the input exactly.
- Empty boundary: single word 0xAB loaded, ready_i=1. Expect exactly one rdreq pulse, one valid_o beat with 0xAB, then valid_o=0 and no further rdreq while fifo_empty_i=1.
- Reset mid-stream, L=1: srst_i=0 for 1 cycle while level_o=2 and a read is in flight. On the next cycle expect valid_o=0, level_o=0, words_o=0 and fifo_rdreq_o=0; then normal operation on new data.
- Counter wrap, CNT_WIDTH=4: 18 words popped. Expect words_o=2.

Source files
------------

// File: rtl/fifo_reader.sv
// fifo_reader: drains a fifo read port onto a valid/ready stream,
// absorbing the fifo read latency with a credit-limited circular buffer.
module fifo_reader #(
   parameter int DWIDTH       = 64,
   parameter int READ_LATENCY = 1,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                 clk_i,
   input  logic                 srst_i,
   input  logic [DWIDTH-1:0]    fifo_q_i,
   input  logic                 fifo_empty_i,
   output logic                 fifo_rdreq_o,
   output logic [DWIDTH-1:0]    data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [2:0]           level_o,
   output logic [CNT_WIDTH-1:0] words_o
);
   localparam int BUF_DEPTH = READ_LATENCY + 2;
   localparam logic [2:0] LAST = 3'(BUF_DEPTH - 1);

   if (READ_LATENCY < 0 || READ_LATENCY > 3) begin : g_bad_latency
      $error("fifo_reader: READ_LATENCY must be in 0..3");
   end

   logic [DWIDTH-1:0]    mem_q [8];
   logic [2:0]           wr_ptr_q, wr_ptr_d;
   logic [2:0]           rd_ptr_q, rd_ptr_d;
   logic [2:0]           level_q, level_d;
   logic [CNT_WIDTH-1:0] words_q, words_d;
   logic [2:0]           inflight;
   logic [3:0]           credit_used;
   logic                 capture;
   logic                 pop;

   // Request only if the buffer can hold every in-flight word plus this one
   assign credit_used  = {1'b0, level_q} + {1'b0, inflight};
   assign fifo_rdreq_o = srst_i && !fifo_empty_i
                         && (credit_used < 4'(BUF_DEPTH));

   if (READ_LATENCY == 0) begin : g_showahead
      assign inflight = 3'd0;
      assign capture  = fifo_rdreq_o;
   end else begin : g_pipe
      logic [READ_LATENCY-1:0] pipe_q, pipe_d;

      always_comb begin
         pipe_d    = pipe_q << 1;
         pipe_d[0] = fifo_rdreq_o;
      end

      always_comb begin
         inflight = 3'd0;
         for (int i = 0; i < READ_LATENCY; i++)
            inflight = inflight + {2'b00, pipe_q[i]};
      end

      assign capture = pipe_q[READ_LATENCY-1];

      always_ff @(posedge clk_i) begin
         if (!srst_i) pipe_q <= '0;
         else         pipe_q <= pipe_d;
      end
   end

   assign pop     = valid_o && ready_i;
   assign valid_o = (level_q != 3'd0);
   assign data_o  = mem_q[rd_ptr_q];
   assign level_o = level_q;
   assign words_o = words_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      words_d  = words_q;
      if (capture)
         wr_ptr_d = (wr_ptr_q == LAST) ? 3'd0 : wr_ptr_q + 3'd1;
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST) ? 3'd0 : rd_ptr_q + 3'd1;
         words_d  = words_q + CNT_WIDTH'(1);
      end
      if (capture && !pop)
         level_d = level_q + 3'd1;
      else if (!capture && pop)
         level_d = level_q - 3'd1;
   end

   always_ff @(posedge clk_i) begin
      if (!srst_i) begin
         wr_ptr_q <= 3'd0;
         rd_ptr_q <= 3'd0;
         level_q  <= 3'd0;
         words_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         words_q  <= words_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i && capture)
         mem_q[wr_ptr_q] <= fifo_q_i;
   end

endmodule
